// File: rtl/core_pkg.sv
// Types shared by the integer datapath: the ALU operation encoding.
package core_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'h0,
    ALU_SUB  = 4'h1,
    ALU_AND  = 4'h2,
    ALU_OR   = 4'h3,
    ALU_XOR  = 4'h4,
    ALU_SLL  = 4'h5,
    ALU_SRL  = 4'h6,
    ALU_SRA  = 4'h7,
    ALU_SLT  = 4'h8,
    ALU_SLTU = 4'h9
  } alu_op_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// One requester's request and response handshakes into the shared ALU arbiter.
interface alu_arbiter_if;

  logic                 req_valid;
  logic                 req_ready;
  logic [31:0]          req_a;
  logic [31:0]          req_b;
  core_pkg::alu_op_t    req_op;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [31:0]          resp_result;
  logic                 resp_zero;

  modport master (
    output req_valid, req_a, req_b, req_op, resp_ready,
    input  req_ready, resp_valid, resp_result, resp_zero
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, resp_ready,
    output req_ready, resp_valid, resp_result, resp_zero
  );

endinterface

// File: rtl/alu_arbiter.sv
// Single-cycle 32-bit ALU shared by two requesters, with a one-entry tagged
// result stage that returns each result to the port that issued it.
module alu
  import core_pkg::*;
(
  input  alu_op_t     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        zero
);

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case leaves it unassigned and infers a latch.
  always_comb begin
    result = '0;
    case (op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_SLL:  result = a << b[4:0];
      ALU_SRL:  result = a >> b[4:0];
      ALU_SRA:  result = $unsigned($signed(a) >>> b[4:0]);
      ALU_SLT:  result = {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU: result = {31'd0, a < b};
      default:  result = '0;
    endcase
  end

  assign zero = (result == 32'd0);

endmodule

module alu_arbiter
  import core_pkg::*;
#(
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  alu_arbiter_if.slave port0,
  alu_arbiter_if.slave port1
);

  logic        out_valid;
  logic        out_tag;
  logic [31:0] out_result;
  logic        out_zero;
  logic        last_grant;

  logic        grant_any;
  logic        grant;
  logic        out_fire;
  logic        can_accept;
  logic        accept;

  alu_op_t     alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_result;
  logic        alu_zero;

  // Round robin favours the port that did not win the last accepted transfer.
  always_comb begin
    grant_any = port0.req_valid | port1.req_valid;
    grant     = 1'b0;
    if (port0.req_valid && port1.req_valid)
      grant = ROUND_ROBIN ? ~last_grant : 1'b0;
    else if (port1.req_valid)
      grant = 1'b1;
  end

  assign out_fire   = out_valid & (out_tag ? port1.resp_ready : port0.resp_ready);
  assign can_accept = ~out_valid | out_fire;
  assign accept     = ~rst & can_accept & grant_any;

  assign port0.req_ready = accept & ~grant & port0.req_valid;
  assign port1.req_ready = accept &  grant & port1.req_valid;

  // An idle ALU sees ADD of zeros; its output is not captured without a grant.
  always_comb begin
    alu_op = ALU_ADD;
    alu_a  = '0;
    alu_b  = '0;
    if (grant_any) begin
      alu_op = grant ? port1.req_op : port0.req_op;
      alu_a  = grant ? port1.req_a  : port0.req_a;
      alu_b  = grant ? port1.req_b  : port0.req_b;
    end
  end

  alu u_alu (
    .op     (alu_op),
    .a      (alu_a),
    .b      (alu_b),
    .result (alu_result),
    .zero   (alu_zero)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_tag    <= 1'b0;
      out_result <= '0;
      out_zero   <= 1'b0;
      last_grant <= 1'b1;
    end else if (accept) begin
      out_valid  <= 1'b1;
      out_tag    <= grant;
      out_result <= alu_result;
      out_zero   <= alu_zero;
      last_grant <= grant;
    end else if (out_fire) begin
      out_valid  <= 1'b0;
    end
  end

  assign port0.resp_valid  = out_valid & ~out_tag;
  assign port1.resp_valid  = out_valid &  out_tag;
  assign port0.resp_result = out_result;
  assign port1.resp_result = out_result;
  assign port0.resp_zero   = out_zero;
  assign port1.resp_zero   = out_zero;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: one round-robin and one fixed-priority instance.
module tb_alu_arbiter;
  import core_pkg::*;

  logic clk;
  logic rst;

  int n_checks;
  int n_fail;

  alu_arbiter_if rr0 ();
  alu_arbiter_if rr1 ();
  alu_arbiter_if fp0 ();
  alu_arbiter_if fp1 ();

  alu_arbiter #(.ROUND_ROBIN(1'b1)) dut_rr (
    .clk   (clk),
    .rst   (rst),
    .port0 (rr0.slave),
    .port1 (rr1.slave)
  );

  alu_arbiter #(.ROUND_ROBIN(1'b0)) dut_fp (
    .clk   (clk),
    .rst   (rst),
    .port0 (fp0.slave),
    .port1 (fp1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle_all();
    rr0.req_valid = 1'b0; rr0.req_a = '0; rr0.req_b = '0; rr0.req_op = ALU_ADD; rr0.resp_ready = 1'b0;
    rr1.req_valid = 1'b0; rr1.req_a = '0; rr1.req_b = '0; rr1.req_op = ALU_ADD; rr1.resp_ready = 1'b0;
    fp0.req_valid = 1'b0; fp0.req_a = '0; fp0.req_b = '0; fp0.req_op = ALU_ADD; fp0.resp_ready = 1'b0;
    fp1.req_valid = 1'b0; fp1.req_a = '0; fp1.req_b = '0; fp1.req_op = ALU_ADD; fp1.resp_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_all();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    idle_all();

    // Readies stay low during reset even with a request pending.
    rr0.req_valid = 1'b1;
    #2;
    check("rst_req0_ready", 32'(rr0.req_ready), 32'd0);
    check("rst_resp0_valid", 32'(rr0.resp_valid), 32'd0);
    check("rst_resp1_valid", 32'(rr1.resp_valid), 32'd0);
    check("rst_result", rr0.resp_result, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single ADD on port 0.
    do_reset();
    rr0.req_valid = 1'b1; rr0.req_a = 32'd5; rr0.req_b = 32'd7; rr0.req_op = ALU_ADD;
    rr0.resp_ready = 1'b1;
    #1;
    check("add_req0_ready", 32'(rr0.req_ready), 32'd1);
    @(posedge clk); #1;
    rr0.req_valid = 1'b0;
    check("add_resp0_valid", 32'(rr0.resp_valid), 32'd1);
    check("add_result", rr0.resp_result, 32'd12);
    check("add_zero", 32'(rr0.resp_zero), 32'd0);
    check("add_resp1_valid", 32'(rr1.resp_valid), 32'd0);
    @(posedge clk); #1;
    check("add_drained", 32'(rr0.resp_valid), 32'd0);

    // Round robin: both ports valid every cycle, grants 0,1,0,1.
    do_reset();
    rr0.req_valid = 1'b1; rr0.req_a = 32'd9;    rr0.req_b = 32'd9;    rr0.req_op = ALU_SUB;
    rr1.req_valid = 1'b1; rr1.req_a = 32'hFF;   rr1.req_b = 32'h0F;   rr1.req_op = ALU_XOR;
    rr0.resp_ready = 1'b1; rr1.resp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("rr_ready0_c%0d", k), 32'(rr0.req_ready), 32'((k % 2) == 0));
      check($sformatf("rr_ready1_c%0d", k), 32'(rr1.req_ready), 32'((k % 2) == 1));
      if (k > 0) begin
        if ((k % 2) == 1) begin
          check($sformatf("rr_resp0_valid_c%0d", k), 32'(rr0.resp_valid), 32'd1);
          check($sformatf("rr_resp0_result_c%0d", k), rr0.resp_result, 32'd0);
          check($sformatf("rr_resp0_zero_c%0d", k), 32'(rr0.resp_zero), 32'd1);
        end else begin
          check($sformatf("rr_resp1_valid_c%0d", k), 32'(rr1.resp_valid), 32'd1);
          check($sformatf("rr_resp1_result_c%0d", k), rr1.resp_result, 32'h0000_00F0);
        end
      end
      @(negedge clk);
    end
    rr0.req_valid = 1'b0; rr1.req_valid = 1'b0;
    #1;
    check("rr_last_resp1_valid", 32'(rr1.resp_valid), 32'd1);
    check("rr_last_resp1_result", rr1.resp_result, 32'h0000_00F0);

    // Backpressure: port 1 SRA result held while resp1_ready is low.
    do_reset();
    rr1.req_valid = 1'b1; rr1.req_a = 32'h8000_0000; rr1.req_b = 32'd4; rr1.req_op = ALU_SRA;
    rr1.resp_ready = 1'b0;
    rr0.resp_ready = 1'b1;
    #1;
    check("bp_req1_ready", 32'(rr1.req_ready), 32'd1);
    @(negedge clk);
    rr1.req_valid = 1'b0;
    rr0.req_valid = 1'b1; rr0.req_a = 32'd1; rr0.req_b = 32'd2; rr0.req_op = ALU_ADD;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("bp_resp1_valid_c%0d", k), 32'(rr1.resp_valid), 32'd1);
      check($sformatf("bp_resp1_result_c%0d", k), rr1.resp_result, 32'hF800_0000);
      check($sformatf("bp_req0_ready_c%0d", k), 32'(rr0.req_ready), 32'd0);
      check($sformatf("bp_resp0_valid_c%0d", k), 32'(rr0.resp_valid), 32'd0);
      @(negedge clk);
    end
    rr1.resp_ready = 1'b1;
    #1;
    check("bp_release_req0_ready", 32'(rr0.req_ready), 32'd1);
    check("bp_release_resp1_valid", 32'(rr1.resp_valid), 32'd1);
    @(posedge clk); #1;
    rr0.req_valid = 1'b0;
    check("bp_after_resp0_valid", 32'(rr0.resp_valid), 32'd1);
    check("bp_after_resp0_result", rr0.resp_result, 32'd3);
    check("bp_after_resp1_valid", 32'(rr1.resp_valid), 32'd0);

    // Fixed priority: port 0 wins every cycle.
    do_reset();
    fp0.req_valid = 1'b1; fp0.req_a = 32'd3; fp0.req_b = 32'd4; fp0.req_op = ALU_OR;
    fp1.req_valid = 1'b1; fp1.req_a = 32'd6; fp1.req_b = 32'd3; fp1.req_op = ALU_AND;
    fp0.resp_ready = 1'b1; fp1.resp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("fp_ready0_c%0d", k), 32'(fp0.req_ready), 32'd1);
      check($sformatf("fp_ready1_c%0d", k), 32'(fp1.req_ready), 32'd0);
      if (k > 0) begin
        check($sformatf("fp_resp0_result_c%0d", k), fp0.resp_result, 32'd7);
        check($sformatf("fp_resp1_valid_c%0d", k), 32'(fp1.resp_valid), 32'd0);
      end
      @(negedge clk);
    end
    fp0.req_valid = 1'b0; fp1.req_valid = 1'b0;

    // Signed vs unsigned compare, then an undefined op code.
    do_reset();
    rr0.req_valid = 1'b1; rr0.req_a = 32'hFFFF_FFFF; rr0.req_b = 32'd1; rr0.req_op = ALU_SLT;
    rr0.resp_ready = 1'b1;
    @(posedge clk); #1;
    check("slt_result", rr0.resp_result, 32'd1);
    check("slt_zero", 32'(rr0.resp_zero), 32'd0);
    rr0.req_op = ALU_SLTU;
    @(posedge clk); #1;
    check("sltu_result", rr0.resp_result, 32'd0);
    check("sltu_zero", 32'(rr0.resp_zero), 32'd1);
    rr0.req_a = 32'h1234_5678; rr0.req_op = alu_op_t'(4'hF);
    @(posedge clk); #1;
    check("undef_result", rr0.resp_result, 32'd0);
    check("undef_zero", 32'(rr0.resp_zero), 32'd1);
    rr0.req_valid = 1'b0;

    // Reset during a stall discards the pending result; port 0 wins first after.
    do_reset();
    rr0.req_valid = 1'b1; rr0.req_a = 32'd1; rr0.req_b = 32'd1; rr0.req_op = ALU_ADD;
    rr0.resp_ready = 1'b0;
    @(posedge clk); #1;
    check("stall_resp0_valid", 32'(rr0.resp_valid), 32'd1);
    check("stall_result", rr0.resp_result, 32'd2);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    check("midrst_resp0_valid", 32'(rr0.resp_valid), 32'd0);
    check("midrst_req0_ready", 32'(rr0.req_ready), 32'd0);
    check("midrst_result", rr0.resp_result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    rr1.req_valid = 1'b1; rr1.req_a = 32'd4; rr1.req_b = 32'd4; rr1.req_op = ALU_ADD;
    rr0.resp_ready = 1'b1; rr1.resp_ready = 1'b1;
    #1;
    check("post_rst_ready0", 32'(rr0.req_ready), 32'd1);
    check("post_rst_ready1", 32'(rr1.req_ready), 32'd0);
    @(posedge clk); #1;
    check("post_rst_resp0_valid", 32'(rr0.resp_valid), 32'd1);
    check("post_rst_resp0_result", rr0.resp_result, 32'd2);
    idle_all();
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single-cycle integer `alu` between two requesters, for example the execute stage (port 0) and the branch/address-generation path (port 1). Each requester uses a valid/ready request handshake and a valid/ready response handshake. The block arbitrates between the ports, drives the internal `alu` instance, and registers the result in a one-entry tagged output stage. That stage routes the result back to the requester that issued it.

## Interface
Parameters:
- `ROUND_ROBIN`, default 1: 1 selects round-robin arbitration; 0 selects fixed priority, port 0 highest.

Ports (`alu_op_t` from `core_pkg`):
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `req0_valid`  in  1  port 0 has an operation pending
- `req0_ready`  out  1  port 0 operation accepted this cycle when high with `req0_valid`
- `req0_a`, `req0_b`  in  32  operands
- `req0_op`  in  `alu_op_t`  operation
- `resp0_valid`  out  1  result for port 0 available
- `resp0_ready`  in  1  port 0 consumes the result
- `resp0_result`  out  32  ALU result
- `resp0_zero`  out  1  result == 0
- `req1_*`, `resp1_*`: identical set for port 1

## Operation
- State:
  - `out_valid` (1b)
  - `out_tag` (1b, owning port)
  - `out_result` (32b)
  - `out_zero` (1b)
  - `last_grant` (1b)
- Reset values:
  - `out_valid`=0, `out_tag`=0, `out_result`=0, `out_zero`=0, `last_grant`=1.
  - All `req*_ready` and `resp*_valid` are 0 while `rst` is high.
- Response mux:
  - `respN_valid` = `out_valid` & (`out_tag`==N).
  - `respN_result`/`respN_zero` = `out_result`/`out_zero` for both ports.
- Drain: `out_fire` = `out_valid` & `resp[out_tag]_ready`.
- Stage free: `can_accept` = !`out_valid` | `out_fire`.
- Grant, combinational:
  - Only one port valid: that port.
  - Both valid with `ROUND_ROBIN`=1: the port != `last_grant`.
  - Both valid with `ROUND_ROBIN`=0: port 0.
  - Neither valid: no grant.
- Ready: `reqN_ready` = `can_accept` & grant==N & `reqN_valid`. At most one ready is high per cycle.
- ALU drive:
  - The granted port's a/b/op drive the `alu` instance.
  - With no grant, the ALU is driven with zero operands and `ALU_ADD`; this never reaches the outputs.
- On accept (`reqN_valid` & `reqN_ready`):
  - `out_result`←ALU result, `out_zero`←ALU zero, `out_tag`←N, `out_valid`←1, `last_grant`←N.
- On `out_fire` with no accept in the same cycle: `out_valid`←0. Data registers hold their values.
- `last_grant` changes only on an accepted transfer. A stalled grant does not rotate priority.
- Arithmetic is exactly that of `alu`:
  - Shifts use `b[4:0]`.
  - `ALU_SLT` is signed; `ALU_SLTU` is unsigned.
  - Undefined op codes give 0 with zero=1.
- Requester rules:
  - Once `reqN_valid` is asserted, a/b/op stay stable until accepted.
  - Valid must not depend combinationally on ready.
  - The block never drops an unaccepted request.

## Timing
- Latency: a request accepted at edge N has its response valid after edge N, i.e. during cycle N+1.
- Throughput: 1 op/cycle sustained when the owning `resp_ready` is high. Accept and drain in the same cycle are allowed.
- Backpressure: while `out_valid` & !`resp[out_tag]_ready`, both `req*_ready` are 0 and the output stage holds.
- Cross-port blocking: port 1 is blocked while port 0's result is unconsumed, and vice versa.
- Combinational paths:
  - `reqN_ready` depends on `req*_valid`, `resp*_ready` and state.
  - No combinational path from requester inputs to `resp*` outputs.
- Reset mid-operation: asserting `rst` immediately clears `out_valid` and the readies, discarding a pending result. Operation resumes on the first edge after deassertion.

## Test plan
- Single op, port 0: ADD a=5, b=7, `resp0_ready`=1 → `resp0_valid` next cycle, result 12, zero 0; `resp1_valid` stays 0.
- Round robin: both ports valid every cycle, port 0 SUB 9-9, port 1 XOR 0xFF^0x0F, both resp_ready=1.
  - Grants alternate 0,1,0,1 starting with port 0 after reset.
  - Port 0 responses: result 0, zero=1.
  - Port 1 responses: result 0xF0.
- Backpressure: port 1 SRA a=0x80000000, b=4 with `resp1_ready`=0 for 3 cycles; port 0 stays valid.
  - `resp1_result`=0xF8000000 held stable.
  - `req0_ready`=0 during the stall.
  - Port 0 is accepted in the same cycle `resp1_ready` rises.
- Fixed priority (`ROUND_ROBIN`=0): both ports valid for 4 cycles → port 0 granted every cycle; port 1 is never ready.
- Comparisons: SLT a=0xFFFFFFFF, b=1 → 1; SLTU with the same operands → 0, zero=1.
- Reset mid-stall: result pending with `resp0_ready`=0, then assert `rst` asynchronously.
  - `resp0_valid` drops immediately.
  - After release, a new request from port 0 gets the grant first (`last_grant`=1).
